// File: rtl/mux_2x1.sv
// 2-to-1 select primitive: Y = S ? i1 : i0, plus a flopped copy Y_q.
// Latency: Y is combinational (0 cycles); Y_q lags the inputs by exactly 1 cycle.
// Backpressure: none, there is no handshake and the output is always valid.
module mux_2x1 #(
  parameter int unsigned            WIDTH   = 1,
  parameter logic [WIDTH-1:0]       RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             S,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Y_q
);

  logic [WIDTH-1:0] y_d;

  // An unknown select must not fall through to i0 or i1. The explicit X
  // branch drives every bit unknown in simulation. Synthesis treats it
  // as don't-care, so the logic reduces to a plain 2:1 mux per bit.
  assign y_d = (S == 1'b1) ? i1 :
               (S == 1'b0) ? i0 : {WIDTH{1'bx}};

  assign Y = y_d;

  // Output flop. The reset is synchronous and takes priority over data on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      Y_q <= RST_VAL;
    end else begin
      Y_q <= y_d;
    end
  end

  // Simulation check: the select must be known whenever the flop is capturing data.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!$isunknown(S))
        else $error("mux_2x1: select S is unknown while out of reset");
    end
  end

endmodule

// File: tb/tb_mux_2x1.sv
// Directed check of mux_2x1 at WIDTH=1 and WIDTH=8: select, flop latency, reset.
// Latency: compares Y 1 time unit after input changes and Y_q 1 time unit after edges.
// Backpressure: none; the bench only drives inputs and samples outputs.
module tb_mux_2x1;

  logic       clk;
  logic       rst;

  logic       a_i0, a_i1, a_s;
  logic       a_y, a_yq;

  logic [7:0] b_i0, b_i1;
  logic       b_s;
  logic [7:0] b_y, b_yq;

  int n_total;
  int n_bad;

  // Expected Y for the eight vectors {i0,i1,S} = 0..7, indexed by the vector.
  logic [7:0] exh_exp;

  mux_2x1 #(.WIDTH(1), .RST_VAL(1'b0)) u_dut_w1 (
    .clk (clk),
    .rst (rst),
    .i0  (a_i0),
    .i1  (a_i1),
    .S   (a_s),
    .Y   (a_y),
    .Y_q (a_yq)
  );

  mux_2x1 #(.WIDTH(8), .RST_VAL(8'h5A)) u_dut_w8 (
    .clk (clk),
    .rst (rst),
    .i0  (b_i0),
    .i1  (b_i1),
    .S   (b_s),
    .Y   (b_y),
    .Y_q (b_yq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] pair;
    logic       sel;
    logic       rexp;

    n_total = 0;
    n_bad   = 0;
    exh_exp = 8'b1101_1000;

    rst  = 1'b1;
    a_i0 = 1'b0; a_i1 = 1'b0; a_s = 1'b0;
    b_i0 = 8'h00; b_i1 = 8'h00; b_s = 1'b0;

    // Reset held for two edges
    repeat (2) @(posedge clk);
    #1;
    check("rst_w1_yq", {7'd0, a_yq}, 8'h00);
    check("rst_w8_yq", b_yq, 8'h5A);

    // Exhaustive WIDTH=1 select table
    for (int i = 0; i < 8; i++) begin
      {a_i0, a_i1, a_s} = i[2:0];
      #1;
      check($sformatf("exh_%0d", i), {7'd0, a_y}, {7'd0, exh_exp[i]});
    end

    // Random WIDTH=1 vectors
    for (int k = 0; k < 12; k++) begin
      pair = 2'($urandom_range(0, 3));
      sel  = 1'($urandom_range(0, 1));
      {a_i1, a_i0} = pair;
      a_s = sel;
      rexp = sel ? pair[1] : pair[0];
      #1;
      check($sformatf("rnd_%0d", k), {7'd0, a_y}, {7'd0, rexp});
    end

    // Register path: release reset, Y=1 must appear on Y_q after one edge
    @(negedge clk);
    rst  = 1'b0;
    a_i0 = 1'b0; a_i1 = 1'b1; a_s = 1'b1;
    #1;
    check("lat_before_edge", {7'd0, a_yq}, 8'h00);
    @(posedge clk);
    #1;
    check("lat_one_edge", {7'd0, a_yq}, 8'h01);

    // Reset pulse between edges has no effect
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("rst_pulse_mid", {7'd0, a_yq}, 8'h01);
    @(posedge clk);
    #1;
    check("rst_pulse_edge", {7'd0, a_yq}, 8'h01);

    // Reset held across an edge wins over Y=1
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_prio_yq", {7'd0, a_yq}, 8'h00);
    check("rst_prio_y", {7'd0, a_y}, 8'h01);
    @(negedge clk);
    rst = 1'b0;

    // WIDTH=8 select and registered copy
    b_i0 = 8'hA5; b_i1 = 8'h3C; b_s = 1'b0;
    #1;
    check("w8_s0_y", b_y, 8'hA5);
    @(posedge clk);
    #1;
    check("w8_s0_yq", b_yq, 8'hA5);
    @(negedge clk);
    b_s = 1'b1;
    #1;
    check("w8_s1_y", b_y, 8'h3C);
    check("w8_s1_yq_hold", b_yq, 8'hA5);
    @(posedge clk);
    #1;
    check("w8_s1_yq", b_yq, 8'h3C);

    // Unknown select, driven and withdrawn between edges
    @(negedge clk);
    b_s = 1'bx;
    #1;
    if ($isunknown(b_s)) begin
      check("xsel_y", b_y, 8'hxx);
    end
    b_s = 1'b0;
    #1;
    check("xsel_restore", b_y, 8'hA5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
